fetch_credit_ctrl: RTL and testbench

FETCH_CREDIT_CTRL -- requirements
Module: fetch_credit_ctrl

---
 rtl/fetch_credit_ctrl.sv | 112 +++++++++++
 tb/tb_fetch_credit_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_credit_ctrl.sv
// Instruction-fetch credit controller: issues I-cache requests within a credit budget,
// forwards in-order responses to the instruction buffer, and drains in-flight fetches on redirect.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal fetch; responses are forwarded into the instruction buffer
// DRAIN | waiting for pre-redirect responses; they are dropped, no requests
module fetch_credit_ctrl #(
    parameter int              DW          = 130,
    parameter int              DEPTH       = 4,
    parameter int              MAX_OUT     = 2,
    parameter int              PC_W        = 32,
    parameter int              FETCH_BYTES = 8,
    parameter logic [PC_W-1:0] RESET_PC    = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            req_valid,
    output logic [PC_W-1:0] req_pc,
    input  logic            req_ready,
    input  logic            rsp_valid,
    input  logic [DW-1:0]   rsp_data,
    output logic [DW-1:0]   ibuf_data,
    output logic            ibuf_push_valid,
    input  logic            ibuf_push_ready,
    input  logic            ibuf_pop,
    output logic            ibuf_flush,
    output logic            overflow_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [PC_W-1:0] pc, pc_next;
    logic [CW-1:0]   credit, credit_next;
    logic [OW-1:0]   outstanding, outstanding_next;
    logic            err_next;
    logic            req_fire, rsp_fwd, rsp_drop, rsp_spurious;

    assign req_pc    = pc;
    assign ibuf_data = rsp_data;

    always_comb begin
        req_valid        = 1'b0;
        ibuf_push_valid  = 1'b0;
        ibuf_flush       = 1'b0;
        req_fire         = 1'b0;
        rsp_fwd          = 1'b0;
        rsp_drop         = 1'b0;
        rsp_spurious     = 1'b0;
        state_next       = state;
        pc_next          = pc;
        credit_next      = credit;
        outstanding_next = outstanding;
        err_next         = overflow_err;

        if (!rst) begin
            req_valid       = (state == RUN) && (credit != '0) &&
                              (outstanding < OW'(MAX_OUT)) && !redirect_valid;
            req_fire        = req_valid && req_ready;
            rsp_fwd         = rsp_valid && (state == RUN) && !redirect_valid;
            rsp_drop        = rsp_valid && !rsp_fwd;
            rsp_spurious    = rsp_valid && (outstanding == '0);
            ibuf_push_valid = rsp_fwd;
            ibuf_flush      = redirect_valid;

            // A response with nothing in flight is flagged, not counted, so the counter cannot wrap.
            outstanding_next = outstanding + OW'(req_fire) - OW'(rsp_valid && !rsp_spurious);

            if (req_fire)
                pc_next = pc + PC_W'(FETCH_BYTES);

            if (redirect_valid) begin
                pc_next     = redirect_pc;
                credit_next = CW'(DEPTH) - CW'(outstanding_next);
                state_next  = (outstanding_next != '0) ? DRAIN : RUN;
            end else begin
                credit_next = credit - CW'(req_fire) + CW'(ibuf_pop) + CW'(rsp_drop);
                if (state == DRAIN && outstanding_next == '0)
                    state_next = RUN;
            end

            if ((rsp_fwd && !ibuf_push_ready) || rsp_spurious)
                err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            pc           <= RESET_PC;
            credit       <= CW'(DEPTH);
            outstanding  <= '0;
            overflow_err <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            credit       <= credit_next;
            outstanding  <= outstanding_next;
            overflow_err <= err_next;
        end
    end

endmodule

// File: tb/tb_fetch_credit_ctrl.sv
// Directed bench for fetch_credit_ctrl: hand-computed expectations for fetch issue,
// credit accounting, redirect/drain, pc wrap and the sticky overflow flag.
module tb_fetch_credit_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         req_valid;
    logic [31:0]  req_pc;
    logic         req_ready;
    logic         rsp_valid;
    logic [129:0] rsp_data;
    logic [129:0] ibuf_data;
    logic         ibuf_push_valid;
    logic         ibuf_push_ready;
    logic         ibuf_pop;
    logic         ibuf_flush;
    logic         overflow_err;

    int n_chk = 0;
    int n_err = 0;
    int pushes = 0;

    logic [129:0] d_a, d_b, d_c, d_d, d_e;

    fetch_credit_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .req_valid       (req_valid),
        .req_pc          (req_pc),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .ibuf_data       (ibuf_data),
        .ibuf_push_valid (ibuf_push_valid),
        .ibuf_push_ready (ibuf_push_ready),
        .ibuf_pop        (ibuf_pop),
        .ibuf_flush      (ibuf_flush),
        .overflow_err    (overflow_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && ibuf_push_valid) pushes++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        d_a = {2'b10, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210};
        d_b = {2'b01, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        d_c = {2'b11, 64'hdead_beef_0000_0001, 64'h0000_0000_cafe_f00d};
        d_d = {2'b00, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001};
        d_e = {2'b10, 64'h0f0f_0f0f_0f0f_0f0f, 64'hf0f0_f0f0_f0f0_f0f0};

        // reset with inputs toggling: they must be ignored
        rst = 1'b1; req_ready = 1'b1; ibuf_push_ready = 1'b1; ibuf_pop = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_4000; rsp_valid = 1'b1; rsp_data = d_a;
        nxt(); nxt();
        chk("rst_req_valid", 32'(req_valid), 0);
        chk("rst_flush", 32'(ibuf_flush), 0);
        chk("rst_push", 32'(ibuf_push_valid), 0);
        chk("rst_req_pc", req_pc, 32'h8000_0000);
        chk("rst_credit", 32'(dut.credit), 4);
        chk("rst_outstanding", 32'(dut.outstanding), 0);
        chk("rst_overflow", 32'(overflow_err), 0);

        // first two fetches, then MAX_OUT stalls issue
        redirect_valid = 1'b0; rsp_valid = 1'b0; rst = 1'b0; #1;
        chk("fetch0_valid", 32'(req_valid), 1);
        chk("fetch0_pc", req_pc, 32'h8000_0000);
        nxt();
        chk("fetch1_valid", 32'(req_valid), 1);
        chk("fetch1_pc", req_pc, 32'h8000_0008);
        nxt();
        chk("maxout_stall", 32'(req_valid), 0);
        chk("maxout_credit", 32'(dut.credit), 2);

        // four responses forwarded with zero latency; credit runs out
        rsp_valid = 1'b1; rsp_data = d_a; #1;
        chk("fwd_a_push", 32'(ibuf_push_valid), 1);
        chk("fwd_a_data", 32'(ibuf_data === d_a), 1);
        nxt();
        rsp_data = d_b; #1;
        chk("fwd_b_data", 32'(ibuf_data === d_b), 1);
        chk("refill_valid", 32'(req_valid), 1);
        nxt();
        rsp_data = d_c; #1;
        chk("fwd_c_push", 32'(ibuf_push_valid), 1);
        nxt();
        rsp_data = d_d; #1;
        chk("fwd_d_data", 32'(ibuf_data === d_d), 1);
        chk("no_credit_stall", 32'(req_valid), 0);
        nxt();
        rsp_valid = 1'b0; #1;
        chk("push_count4", pushes, 4);
        chk("credit_zero", 32'(dut.credit), 0);
        chk("credit_zero_stall", 32'(req_valid), 0);
        ibuf_pop = 1'b1;
        nxt();
        ibuf_pop = 1'b0; #1;
        chk("pop_credit", 32'(dut.credit), 1);
        chk("pop_req_valid", 32'(req_valid), 1);
        chk("pop_req_pc", req_pc, 32'h8000_0020);
        nxt();
        chk("one_out_credit0", 32'(req_valid), 0);

        // redirect with a same-cycle response, outstanding=1: straight back to RUN
        redirect_valid = 1'b1; redirect_pc = 32'h0000_3000; rsp_valid = 1'b1; rsp_data = d_e; #1;
        chk("redir1_flush", 32'(ibuf_flush), 1);
        chk("redir1_drop", 32'(ibuf_push_valid), 0);
        chk("redir1_req_valid", 32'(req_valid), 0);
        nxt();
        redirect_valid = 1'b0; rsp_valid = 1'b0; #1;
        chk("redir1_outstanding", 32'(dut.outstanding), 0);
        chk("redir1_credit", 32'(dut.credit), 4);
        chk("redir1_run_valid", 32'(req_valid), 1);
        chk("redir1_pc", req_pc, 32'h0000_3000);

        // redirect with two in flight: drain drops both responses
        nxt(); nxt();
        chk("out2_stall", 32'(req_valid), 0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1000; #1;
        chk("redir2_flush", 32'(ibuf_flush), 1);
        nxt();
        redirect_valid = 1'b0; #1;
        chk("drain_no_req", 32'(req_valid), 0);
        chk("drain_credit", 32'(dut.credit), 2);
        rsp_valid = 1'b1; rsp_data = d_a; #1;
        chk("drain_drop0", 32'(ibuf_push_valid), 0);
        nxt();
        chk("drain_drop1", 32'(ibuf_push_valid), 0);
        chk("drain_still_no_req", 32'(req_valid), 0);
        nxt();
        rsp_valid = 1'b0; #1;
        chk("drain_done_valid", 32'(req_valid), 1);
        chk("drain_done_pc", req_pc, 32'h0000_1000);
        chk("drain_done_credit", 32'(dut.credit), 4);
        chk("drain_push_count", pushes, 4);

        // second redirect during drain: newest pc wins
        nxt(); nxt();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1800; #1;
        chk("redir3_flush", 32'(ibuf_flush), 1);
        nxt();
        redirect_pc = 32'h0000_2000; #1;
        chk("redir4_flush", 32'(ibuf_flush), 1);
        nxt();
        redirect_valid = 1'b0; rsp_valid = 1'b1; #1;
        chk("redir4_drain", 32'(req_valid), 0);
        nxt(); nxt();
        rsp_valid = 1'b0; #1;
        chk("redir4_valid", 32'(req_valid), 1);
        chk("redir4_pc", req_pc, 32'h0000_2000);

        // forwarded push into a full buffer sets the sticky error
        nxt();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = d_e; ibuf_push_ready = 1'b0; #1;
        chk("ovf_push", 32'(ibuf_push_valid), 1);
        chk("ovf_not_yet", 32'(overflow_err), 0);
        nxt();
        rsp_valid = 1'b0; ibuf_push_ready = 1'b1; #1;
        chk("ovf_set", 32'(overflow_err), 1);

        // pc wraps modulo 2^32
        redirect_valid = 1'b1; redirect_pc = 32'hffff_fff8;
        nxt();
        redirect_valid = 1'b0; req_ready = 1'b1; #1;
        chk("wrap_pc0", req_pc, 32'hffff_fff8);
        nxt();
        req_ready = 1'b0; #1;
        chk("wrap_pc1", req_pc, 32'h0000_0000);
        chk("ovf_sticky", 32'(overflow_err), 1);

        // reset clears the error; a response with nothing outstanding sets it
        rst = 1'b1;
        nxt();
        rst = 1'b0; #1;
        chk("rst2_overflow", 32'(overflow_err), 0);
        chk("rst2_pc", req_pc, 32'h8000_0000);
        chk("rst2_credit", 32'(dut.credit), 4);
        nxt();
        rsp_valid = 1'b1;
        nxt();
        rsp_valid = 1'b0; #1;
        chk("spurious_ovf", 32'(overflow_err), 1);
        chk("spurious_outstanding", 32'(dut.outstanding), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
